id_ex_stage: RTL and testbench

- Pipeline register between instruction decode (ID) and execute (EX) of the Antares-R2 five-stage MIPS pipeline.
- Integrates load-use hazard detection, bubble insertion, branch flush and external stall handling.
- Drives rsEX/rtEX, consumed by the EX forwarding selectors.
- Drives the EX-stage operands and controls, and the freeze signal for the PC and IF/ID register.

---
 rtl/id_ex_stage_if.sv | 31 +++
 rtl/id_ex_stage.sv | 95 +++++++++
 tb/tb_id_ex_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID-side and EX-side signal bundle of the ID/EX pipeline register.
// The master drives the decoded ID fields; the slave (the stage) drives the registered EX fields.
interface id_ex_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  validID;
    logic [4:0]            rsID, rtID, rdID;
    logic [DATA_WIDTH-1:0] readData1ID, readData2ID, immID;
    logic                  regWriteID, memReadID, memWriteID, memToRegID, aluSrcID;
    logic [3:0]            aluOpID;

    logic                  validEX;
    logic [4:0]            rsEX, rtEX, rdEX;
    logic [DATA_WIDTH-1:0] readData1EX, readData2EX, immEX;
    logic                  regWriteEX, memReadEX, memWriteEX, memToRegEX, aluSrcEX;
    logic [3:0]            aluOpEX;

    modport master (
        output validID, rsID, rtID, rdID, readData1ID, readData2ID, immID,
               regWriteID, memReadID, memWriteID, memToRegID, aluSrcID, aluOpID,
        input  validEX, rsEX, rtEX, rdEX, readData1EX, readData2EX, immEX,
               regWriteEX, memReadEX, memWriteEX, memToRegEX, aluSrcEX, aluOpEX
    );

    modport slave (
        input  validID, rsID, rtID, rdID, readData1ID, readData2ID, immID,
               regWriteID, memReadID, memWriteID, memToRegID, aluSrcID, aluOpID,
        output validEX, rsEX, rtEX, rdEX, readData1EX, readData2EX, immEX,
               regWriteEX, memReadEX, memWriteEX, memToRegEX, aluSrcEX, aluOpEX
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// external stall with deferred flush, and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stallExt,
    input  logic                   flush,
    id_ex_if.slave                 bus,
    output logic                   stallIFID,
    output logic [COUNT_WIDTH-1:0] bubbleCount
);
    typedef struct packed {
        logic                  valid;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic [3:0]            alu_op;
    } ex_t;

    ex_t  ex_q;
    ex_t  ex_capture;
    logic pending_flush;
    logic flush_eff;
    logic load_use;
    logic count_full;

    always_comb begin
        flush_eff  = flush | pending_flush;
        load_use   = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) & bus.validID
                   & ((ex_q.rt == bus.rsID) | (ex_q.rt == bus.rtID));
        stallIFID  = stallExt | (load_use & ~flush_eff);
        count_full = &bubbleCount;
    end

    // Side-effecting controls of an invalid ID slot are killed so EX never acts on it.
    always_comb begin
        ex_capture.valid      = bus.validID;
        ex_capture.rs         = bus.rsID;
        ex_capture.rt         = bus.rtID;
        ex_capture.rd         = bus.rdID;
        ex_capture.rd1        = bus.readData1ID;
        ex_capture.rd2        = bus.readData2ID;
        ex_capture.imm        = bus.immID;
        ex_capture.reg_write  = bus.regWriteID & bus.validID;
        ex_capture.mem_read   = bus.memReadID  & bus.validID;
        ex_capture.mem_write  = bus.memWriteID & bus.validID;
        ex_capture.mem_to_reg = bus.memToRegID;
        ex_capture.alu_src    = bus.aluSrcID;
        ex_capture.alu_op     = bus.aluOpID;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_q          <= '0;
            pending_flush <= 1'b0;
            bubbleCount   <= '0;
        end else if (stallExt) begin
            if (flush) pending_flush <= 1'b1;
        end else if (flush_eff) begin
            ex_q          <= '0;
            pending_flush <= 1'b0;
            if (!count_full) bubbleCount <= bubbleCount + 1'b1;
        end else if (load_use) begin
            ex_q <= '0;
            if (!count_full) bubbleCount <= bubbleCount + 1'b1;
        end else begin
            ex_q <= ex_capture;
        end
    end

    assign bus.validEX     = ex_q.valid;
    assign bus.rsEX        = ex_q.rs;
    assign bus.rtEX        = ex_q.rt;
    assign bus.rdEX        = ex_q.rd;
    assign bus.readData1EX = ex_q.rd1;
    assign bus.readData2EX = ex_q.rd2;
    assign bus.immEX       = ex_q.imm;
    assign bus.regWriteEX  = ex_q.reg_write;
    assign bus.memReadEX   = ex_q.mem_read;
    assign bus.memWriteEX  = ex_q.mem_write;
    assign bus.memToRegEX  = ex_q.mem_to_reg;
    assign bus.aluSrcEX    = ex_q.alu_src;
    assign bus.aluOpEX     = ex_q.alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use, false hazards, flush,
// deferred flush under external stall, reset mid-stall and counter saturation.
module tb_id_ex_stage;
    logic       clock = 1'b0;
    logic       reset;
    logic       stallExt;
    logic       flush;
    logic       stallIFID;
    logic [3:0] bubbleCount;
    int         errors = 0;
    int         checks = 0;

    id_ex_if #(.DATA_WIDTH(32)) bus ();

    id_ex_stage #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .stallExt    (stallExt),
        .flush       (flush),
        .bus         (bus.slave),
        .stallIFID   (stallIFID),
        .bubbleCount (bubbleCount)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic rw, input logic mr,
                            input logic [31:0] d1);
        bus.validID     = v;
        bus.rsID        = rs;
        bus.rtID        = rt;
        bus.rdID        = rd;
        bus.readData1ID = d1;
        bus.readData2ID = d1 + 32'h11;
        bus.immID       = d1 + 32'h22;
        bus.regWriteID  = rw;
        bus.memReadID   = mr;
        bus.memWriteID  = 1'b0;
        bus.memToRegID  = mr;
        bus.aluSrcID    = mr;
        bus.aluOpID     = 4'h2;
    endtask

    initial begin
        reset = 1'b0;
        stallExt = 1'b0;
        flush = 1'b0;
        drive_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, $urandom);
        tick();
        drive_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, $urandom);
        tick();
        chk("rst_validEX", 64'(bus.validEX), 64'd0);
        chk("rst_rsEX", 64'(bus.rsEX), 64'd0);
        chk("rst_readData1EX", 64'(bus.readData1EX), 64'd0);
        chk("rst_memReadEX", 64'(bus.memReadEX), 64'd0);
        chk("rst_aluOpEX", 64'(bus.aluOpEX), 64'd0);
        chk("rst_bubbleCount", 64'(bubbleCount), 64'd0);
        chk("rst_stallIFID", 64'(stallIFID), 64'd0);

        // first capture after reset release
        drive_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 32'h0000_00AA);
        reset = 1'b1;
        tick();
        chk("cap_rsEX", 64'(bus.rsEX), 64'd5);
        chk("cap_rdEX", 64'(bus.rdEX), 64'd7);
        chk("cap_readData1EX", 64'(bus.readData1EX), 64'hAA);
        chk("cap_readData2EX", 64'(bus.readData2EX), 64'hBB);
        chk("cap_immEX", 64'(bus.immEX), 64'hCC);
        chk("cap_validEX", 64'(bus.validEX), 64'd1);
        chk("cap_aluOpEX", 64'(bus.aluOpEX), 64'd2);

        // load-use: lw $8 then add using $8
        drive_id(1'b1, 5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 32'h100);
        tick();
        chk("lw_memReadEX", 64'(bus.memReadEX), 64'd1);
        drive_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 32'h200);
        #1;
        chk("lu_stallIFID", 64'(stallIFID), 64'd1);
        tick();
        chk("lu_bub_validEX", 64'(bus.validEX), 64'd0);
        chk("lu_bub_regWriteEX", 64'(bus.regWriteEX), 64'd0);
        chk("lu_bub_rtEX", 64'(bus.rtEX), 64'd0);
        chk("lu_bub_readData1EX", 64'(bus.readData1EX), 64'd0);
        chk("lu_bubbleCount", 64'(bubbleCount), 64'd1);
        chk("lu_stall_drop", 64'(stallIFID), 64'd0);
        tick();
        chk("lu_add_rsEX", 64'(bus.rsEX), 64'd8);
        chk("lu_add_rdEX", 64'(bus.rdEX), 64'd10);
        chk("lu_add_validEX", 64'(bus.validEX), 64'd1);
        chk("lu_add_count", 64'(bubbleCount), 64'd1);

        // lw to $0 followed by a use of $0
        drive_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 32'h300);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 32'h400);
        #1;
        chk("zero_stallIFID", 64'(stallIFID), 64'd0);
        tick();
        chk("zero_rdEX", 64'(bus.rdEX), 64'd11);
        chk("zero_count", 64'(bubbleCount), 64'd1);

        // lw $12 followed by an invalid ID slot naming $12
        drive_id(1'b1, 5'd2, 5'd12, 5'd12, 1'b1, 1'b1, 32'h500);
        tick();
        drive_id(1'b0, 5'd12, 5'd12, 5'd13, 1'b1, 1'b1, 32'h600);
        #1;
        chk("inv_stallIFID", 64'(stallIFID), 64'd0);
        tick();
        chk("inv_validEX", 64'(bus.validEX), 64'd0);
        chk("inv_regWriteEX", 64'(bus.regWriteEX), 64'd0);
        chk("inv_memReadEX", 64'(bus.memReadEX), 64'd0);
        chk("inv_rsEX", 64'(bus.rsEX), 64'd12);
        chk("inv_count", 64'(bubbleCount), 64'd1);

        // flush together with load-use
        drive_id(1'b1, 5'd2, 5'd13, 5'd13, 1'b1, 1'b1, 32'h700);
        tick();
        drive_id(1'b1, 5'd13, 5'd1, 5'd14, 1'b1, 1'b0, 32'h800);
        flush = 1'b1;
        #1;
        chk("fl_lu_stallIFID", 64'(stallIFID), 64'd0);
        tick();
        flush = 1'b0;
        chk("fl_lu_validEX", 64'(bus.validEX), 64'd0);
        chk("fl_lu_rsEX", 64'(bus.rsEX), 64'd0);
        chk("fl_lu_count", 64'(bubbleCount), 64'd2);

        // deferred flush across a 3-cycle external stall
        drive_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 32'h900);
        tick();
        chk("df_pre_rdEX", 64'(bus.rdEX), 64'd5);
        drive_id(1'b1, 5'd20, 5'd22, 5'd21, 1'b1, 1'b0, 32'hA00);
        stallExt = 1'b1;
        flush = 1'b1;
        #1;
        chk("df_stallIFID", 64'(stallIFID), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            flush = 1'b0;
            chk($sformatf("df_hold_rdEX_%0d", i), 64'(bus.rdEX), 64'd5);
            chk($sformatf("df_hold_validEX_%0d", i), 64'(bus.validEX), 64'd1);
            chk($sformatf("df_hold_count_%0d", i), 64'(bubbleCount), 64'd2);
        end
        stallExt = 1'b0;
        #1;
        chk("df_release_stallIFID", 64'(stallIFID), 64'd0);
        tick();
        chk("df_bub_validEX", 64'(bus.validEX), 64'd0);
        chk("df_bub_rdEX", 64'(bus.rdEX), 64'd0);
        chk("df_bub_count", 64'(bubbleCount), 64'd3);
        tick();
        chk("df_after_rdEX", 64'(bus.rdEX), 64'd21);
        chk("df_after_validEX", 64'(bus.validEX), 64'd1);
        chk("df_after_count", 64'(bubbleCount), 64'd3);

        // reset during a stall with a pending flush
        stallExt = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        reset = 1'b0;
        tick();
        chk("rm_validEX", 64'(bus.validEX), 64'd0);
        chk("rm_rdEX", 64'(bus.rdEX), 64'd0);
        chk("rm_count", 64'(bubbleCount), 64'd0);
        reset = 1'b1;
        stallExt = 1'b0;
        tick();
        chk("rm_after_rdEX", 64'(bus.rdEX), 64'd21);
        chk("rm_after_validEX", 64'(bus.validEX), 64'd1);
        chk("rm_after_count", 64'(bubbleCount), 64'd0);

        // saturation of the 4-bit counter after 18 forced bubbles
        flush = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i == 14) chk("sat_count_15", 64'(bubbleCount), 64'd15);
        end
        chk("sat_count_held", 64'(bubbleCount), 64'd15);
        chk("sat_validEX", 64'(bus.validEX), 64'd0);
        flush = 1'b0;
        tick();
        chk("sat_resume_validEX", 64'(bus.validEX), 64'd1);
        chk("sat_resume_count", 64'(bubbleCount), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
